// File: rtl/partial_sum_accumulator_if.sv
// Term/result handshake bundle between the merge stage, the accumulator and the
// activation writeback path.
interface partial_sum_accumulator_if #(
   parameter int BIT_WIDTH = 8,
   parameter int CNT_WIDTH = 8
);
   logic [CNT_WIDTH-1:0] acc_len;
   logic                 relu_en;
   logic                 in_valid;
   logic [BIT_WIDTH-1:0] in_data;
   logic                 in_ready;
   logic                 out_valid;
   logic [BIT_WIDTH-1:0] out_data;
   logic                 out_ready;
   logic                 busy;

   modport master (
      output acc_len, relu_en, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  acc_len, relu_en, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/partial_sum_accumulator.sv
// Accumulates a runtime-sized group of signed partial sums, applies optional ReLU,
// saturates to the activation width and holds the result in a one-entry output register.
module partial_sum_accumulator #(
   parameter int BIT_WIDTH = 8,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   partial_sum_accumulator_if.slave bus
);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (BIT_WIDTH-1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      ACC_WIDTH'(-(64'sd1 <<< (BIT_WIDTH-1)));

   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]        len_q, len_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        out_valid_q, out_valid_d;
   logic [BIT_WIDTH-1:0]        out_data_q, out_data_d;

   logic                        first_term;
   logic                        is_last;
   logic [CNT_WIDTH-1:0]        eff_len;
   logic signed [ACC_WIDTH-1:0] term_ext;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] relu_sum;
   logic [BIT_WIDTH-1:0]        sat_data;
   logic                        in_ready;
   logic                        accept;
   logic                        drain;

   always_comb begin
      first_term = (cnt_q == '0);
      // On a group's first term the length comes straight from the port, 0 meaning 1.
      eff_len = len_q;
      if (first_term) begin
         eff_len = (bus.acc_len == '0) ? CNT_WIDTH'(1) : bus.acc_len;
      end
      is_last = (cnt_q == eff_len - CNT_WIDTH'(1));

      term_ext = {{(ACC_WIDTH-BIT_WIDTH){bus.in_data[BIT_WIDTH-1]}}, bus.in_data};
      sum      = first_term ? term_ext : acc_q + term_ext;
      relu_sum = (bus.relu_en && sum[ACC_WIDTH-1]) ? '0 : sum;

      if (relu_sum > SAT_MAX) begin
         sat_data = {1'b0, {(BIT_WIDTH-1){1'b1}}};
      end else if (relu_sum < SAT_MIN) begin
         sat_data = {1'b1, {(BIT_WIDTH-1){1'b0}}};
      end else begin
         sat_data = relu_sum[BIT_WIDTH-1:0];
      end

      // Only a closing term needs room in the output register; others always go in.
      in_ready = !rst && !(is_last && out_valid_q && !bus.out_ready);
      accept   = bus.in_valid && in_ready;
      drain    = out_valid_q && bus.out_ready;

      cnt_d       = cnt_q;
      len_d       = len_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (drain) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         acc_d = sum;
         if (first_term) begin
            len_d = eff_len;
         end
         if (is_last) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = sat_data;
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         len_q       <= CNT_WIDTH'(1);
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (cnt_q != '0);
endmodule
